branch_history_table: RTL and testbench
=======================================

# branch_history_table

Direct-mapped table of 2-bit saturating counters that gives the fetch stage a taken/not-taken prediction and is trained by the resolution record produced by the branch unit control unit. It sits downstream of the branch unit (consumes `res_i`) and beside fetch (serves `fetch_pc_i` lookups). A post-reset sweep initialises every entry before the table accepts traffic.

## Interface
- `LEN`, 64: number of entries; power of two, ≥ 4. `IDX = $clog2(LEN)`.
- `XLEN`, 32: PC width.

- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low. Clock is `clk_i`.
- `fetch_valid_i`  in  1  lookup request this cycle.
- `fetch_pc_i`  in  XLEN  lookup PC.
- `pred_valid_o`  out  1  registered; prediction available for the previous cycle's lookup.
- `pred_taken_o`  out  1  registered; predicted direction.
- `res_i`  in  `resolution_t` (mmm_pkg)  training input. Only `valid`, `taken` and `pc` are used. `mispredict` and `target` are ignored.
- `ready_o`  out  1  high once the init sweep has finished. Lookups and updates are honoured only while it is high.

## Operation
- Index is `pc[IDX+1:2]` for both lookup and update. Bits `[1:0]` and bits above `IDX+1` are ignored, so aliasing is accepted.
- Counter encoding:
  - `00` strong NT.
  - `01` weak NT.
  - `10` weak T.
  - `11` strong T.
  - Prediction is the counter MSB.
- Update rule: `taken=1` increments the counter, saturating at `11`. `taken=0` decrements it, saturating at `00`.
- FSM states: `INIT`, `RUN`.
  - `INIT`:
    - Entered asynchronously on reset, with `init_idx=0`.
    - Each cycle writes `01` to `table[init_idx]` and increments `init_idx`.
    - Moves to `RUN` after the cycle that writes index `LEN-1`.
    - `ready_o=0`, `pred_valid_o=0`.
    - `res_i.valid` and `fetch_valid_i` are dropped with no side effect.
  - `RUN`: `ready_o=1`. Stays here until reset.
- Lookup (`RUN`): if `fetch_valid_i` is high in cycle t, then in cycle t+1 `pred_valid_o=1` and `pred_taken_o` equals the MSB of the indexed counter. If `fetch_valid_i` is low, `pred_valid_o=0` in t+1 and `pred_taken_o` holds its last value.
- Update (`RUN`): `res_i.valid` in cycle t writes the new counter at the t→t+1 edge. At most one update per cycle.
- Simultaneous lookup and update to the same index in cycle t: the prediction uses the post-update counter (bypass).
- Simultaneous lookup and update to different indices: the two are independent.
- Only the table storage is written; no other state changes on update.

## Timing
- Reset values:
  - state `INIT`.
  - `init_idx=0`.
  - `ready_o=0`.
  - `pred_valid_o=0`.
  - `pred_taken_o=0`.
  - Table contents are undefined until the sweep completes.
- The sweep takes exactly `LEN` cycles. With reset deasserted before edge 1, `ready_o` is high from just after edge `LEN`.
- Lookup latency is 1 cycle, with a registered output. Update is visible to a lookup issued in the next cycle, or in the same cycle via bypass.
- Reset asserted mid-sweep or mid-run: outputs return to their reset values immediately and the sweep restarts from index 0.
- `ready_o` is a status signal, not a handshake. Upstream must hold off until it is high; requests issued before then are lost.
- No backpressure: one lookup and one update are accepted every cycle in `RUN`.

## Test plan
- **Init sweep.** `LEN=64`; release reset; drive `fetch_valid_i=1` with PC 0x0 throughout.
  - `ready_o` rises after exactly 64 cycles.
  - `pred_valid_o=0` throughout the sweep.
  - The first prediction after ready is `pred_taken_o=0` (weak NT).
- **Training and saturation.** Send 3 taken updates for PC 0x100, then look it up → `pred_taken_o=1`, counter `11`. Then send 1 not-taken and look up → still 1 (`10`). Then send 2 more not-taken → 0 (`00`). Then send one further not-taken → it stays at `00`.
- **Aliasing.** With `LEN=64`, train PC 0x100 taken twice, then look up PC 0x200 (same index `0x00`) → `pred_taken_o=1`. Look up PC 0x104 → 0.
- **Bypass.** PC 0x40 is at `01`. In the same cycle drive a taken update on 0x40 and a lookup of 0x40 → the next-cycle `pred_taken_o=1`. Repeat with lookup 0x44 → 0.
- **Drop during init and reset mid-operation.**
  - Updates driven during `INIT` leave all entries at `01`.
  - After training PC 0x100 to `11`, assert `rst_n_i` for 1 cycle. Outputs clear immediately, `ready_o` returns after 64 cycles, and the lookup of 0x100 gives 0.
- **Idle lookup.** Drop `fetch_valid_i` for one cycle → `pred_valid_o=0` next cycle and `pred_taken_o` holds its previous value.

Source files
------------

// File: rtl/branch_history_table.sv
// Branch history table: direct-mapped 2-bit saturating counters.
// Predicts for fetch and trains from resolved branches.
package mmm_pkg;
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic        mispredict;
    logic [31:0] pc;
    logic [31:0] target;
  } resolution_t;
endpackage

module branch_history_table
  import mmm_pkg::*;
#(
  parameter  int LEN  = 64,
  parameter  int XLEN = 32,
  localparam int IDX  = $clog2(LEN)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            fetch_valid_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  input  resolution_t     res_i,
  output logic            ready_o
);

  typedef enum logic {INIT, RUN} state_t;

  state_t         state_q, state_d;
  logic [IDX-1:0] init_idx_q, init_idx_d;
  logic [1:0]     tbl_q [LEN];
  logic [IDX-1:0] look_idx, upd_idx;
  logic [1:0]     upd_old, upd_new;
  logic           run, look_taken;
  logic           unused_ok;

  assign look_idx  = fetch_pc_i[IDX+1:2];
  assign upd_idx   = res_i.pc[IDX+1:2];
  assign upd_old   = tbl_q[upd_idx];
  assign ready_o   = run;
  assign unused_ok = ^{fetch_pc_i, res_i};

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    run        = 1'b0;
    unique case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + IDX'(1);
        if (init_idx_q == IDX'(LEN-1))
          state_d = RUN;
      end
      RUN: run = 1'b1;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    upd_new = upd_old;
    unique case (1'b1)
      res_i.taken && upd_old != 2'b11:
        upd_new = upd_old + 2'd1;
      !res_i.taken && upd_old != 2'b00:
        upd_new = upd_old - 2'd1;
      default: ;
    endcase
  end

  // Same-cycle update to the looked-up entry is forwarded.
  always_comb begin
    look_taken = tbl_q[look_idx][1];
    if (res_i.valid && upd_idx == look_idx)
      look_taken = upd_new[1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= INIT;
      init_idx_q   <= '0;
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      pred_valid_o <= run && fetch_valid_i;
      if (run && fetch_valid_i)
        pred_taken_o <= look_taken;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!run)
      tbl_q[init_idx_q] <= 2'b01;
    else if (res_i.valid)
      tbl_q[upd_idx] <= upd_new;
  end

endmodule

// File: tb/tb_branch_history_table.sv
// Bench for branch_history_table: queue scoreboard
// against a counter-array model with random traffic.
module tb_branch_history_table;
  import mmm_pkg::*;

  localparam int LEN = 64;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] fetch_pc_i = '0;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic        ready_o;
  resolution_t res_i;

  always #5 clk_i = ~clk_i;

  branch_history_table #(.LEN(LEN), .XLEN(32)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .fetch_valid_i(fetch_valid_i),
    .fetch_pc_i   (fetch_pc_i),
    .pred_valid_o (pred_valid_o),
    .pred_taken_o (pred_taken_o),
    .res_i        (res_i),
    .ready_o      (ready_o)
  );

  typedef struct {
    int due;
    bit valid;
    bit taken;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   ctr [LEN];
  bit   last_taken = 1'b0;
  bit   in_run = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(string nm, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  function automatic int idx(logic [31:0] pc);
    return int'((pc / 4) % LEN);
  endfunction

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 1) == 1) return $urandom();
    return ($urandom_range(0, 3) << 8) | $urandom_range(0, 255);
  endfunction

  // Monitor: one expectation falls due each cycle in RUN.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_n_i) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("pred_valid", int'(pred_valid_o), int'(e.valid));
        check("pred_taken", int'(pred_taken_o), int'(e.taken));
      end else if (pred_valid_o) begin
        check("unexpected_pred_valid", 1, 0);
      end
    end
  end

  task automatic step(bit fv, logic [31:0] pc,
                      bit rv, bit rt, logic [31:0] rpc);
    exp_t e;
    int   k;
    fetch_valid_i    = fv;
    fetch_pc_i       = pc;
    res_i.valid      = rv;
    res_i.taken      = rt;
    res_i.pc         = rpc;
    res_i.mispredict = 1'($urandom());
    res_i.target     = $urandom();
    if (in_run) begin
      if (rv) begin
        k = idx(rpc);
        if (rt) ctr[k] = (ctr[k] == 3) ? 3 : ctr[k] + 1;
        else    ctr[k] = (ctr[k] == 0) ? 0 : ctr[k] - 1;
      end
      if (fv) last_taken = (ctr[idx(pc)] >= 2);
      e.due   = cyc + 1;
      e.valid = fv;
      e.taken = last_taken;
      q.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_and_sweep();
    int k;
    int bad;
    @(negedge clk_i);
    #1;
    rst_n_i = 1'b0;
    in_run  = 1'b0;
    #1;
    check("rst_ready", int'(ready_o), 0);
    check("rst_pred_valid", int'(pred_valid_o), 0);
    check("rst_pred_taken", int'(pred_taken_o), 0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    foreach (ctr[i]) ctr[i] = 1;
    last_taken = 1'b0;
    bad = 0;
    for (k = 1; k <= 200; k++) begin
      step(1'b1, 32'h0, 1'($urandom()), 1'($urandom()), rnd_pc());
      if (pred_valid_o) bad++;
      if (ready_o) break;
    end
    check("ready_after_edges", k, LEN);
    check("pred_valid_in_init", bad, 0);
    in_run = 1'b1;
  endtask

  // Plain lookups, then taken+lookup bypass on each entry.
  task automatic verify_init();
    logic [31:0] pc;
    for (int i = 0; i < LEN; i++) begin
      pc = ($urandom() << 8) | 32'(i * 4) | 32'($urandom_range(0, 3));
      step(1'b1, pc, 1'b0, 1'b0, 32'h0);
    end
    for (int i = 0; i < LEN; i++) begin
      pc = 32'(i * 4);
      step(1'b1, pc, 1'b1, 1'b1, pc + 32'h400);
    end
  endtask

  initial begin
    res_i = '0;
    #3;
    reset_and_sweep();
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100);
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100);
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
    step(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h40, 1'b1, 1'b1, 32'h40);
    step(1'b1, 32'h44, 1'b1, 1'b1, 32'h40);
    step(1'b0, 32'h40, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h44, 1'b1, 1'b0, 32'h40);
    verify_init();
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    reset_and_sweep();
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    verify_init();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, rnd_pc(),
           1'($urandom()), 1'($urandom()), rnd_pc());
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    #1;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
